ifetch_buffer: RTL and testbench
================================

Name: ifetch_buffer

Overview:
- Instruction prefetch queue between the CPU fetch stage and a variable-latency instruction memory port.
- Issues in-order word fetch requests ahead of the core and buffers returned instructions with their PCs.
- Presents one instruction per cycle to the IF/ID pipeline register under a valid/ready handshake.
- Flushes the buffer and discards in-flight responses on a control-flow redirect from NPC resolution.

Parameters:
- DEPTH, 4, number of buffer entries; also the cap on requests allocated plus stale requests in flight; power of two, at least 2
- WORD_WIDTH, 32, instruction and address width
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_req_addr  out  WORD_WIDTH  word-aligned fetch address
- mem_rsp_valid  in  1  instruction returned; responses are in order and always accepted
- mem_rsp_data  in  WORD_WIDTH  returned instruction
- if_valid  out  1  head entry holds an instruction
- if_ready  in  1  core consumes the head (deasserted on stall_ID)
- if_pc  out  WORD_WIDTH  PC of the head instruction
- if_pc4  out  WORD_WIDTH  if_pc+4, modulo 2^WORD_WIDTH
- if_instr  out  WORD_WIDTH  head instruction
- redirect  in  1  branch/jump taken: flush and refetch
- redirect_pc  in  WORD_WIDTH  new fetch PC; bits [1:0] ignored and forced to 0

Behaviour:
- Reset is asynchronous, active-high, and is the only reset in the block:
  - fetch_pc = RESET_PC, count = 0, alloc/fill/head pointers = 0, drop_cnt = 0.
  - if_valid = 0 and mem_req_valid = 0 while rst is high.
  - The first request is issued in the first cycle after rst deasserts.
- Each entry holds {pc, instr, filled}.
  - count = number of allocated entries, 0..DEPTH.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Request rule:
  - mem_req_valid = !rst && !redirect && (count + drop_cnt < DEPTH).
  - mem_req_addr = fetch_pc.
  - On mem_req_valid && mem_req_ready: allocate the entry at alloc_ptr with pc = fetch_pc and filled = 0; fetch_pc += 4 (wraps 0xFFFFFFFC -> 0x0).
  - mem_req_valid is held with a stable address until accepted, unless redirect occurs.
- Response rule:
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise it writes instr at fill_ptr, sets filled, and fill_ptr advances.
  - A response with no outstanding request is an error and is asserted in simulation.
- Output:
  - if_valid = entry[head].filled; if_pc, if_pc4, and if_instr come from entry[head].
  - Fill-to-output latency is 1 cycle (response at edge t, if_valid high after edge t).
  - Pop on if_valid && if_ready: head advances, count decrements.
- Simultaneous events without redirect:
  - Allocate, fill, and pop may all occur in the same cycle.
  - count_next = count + alloc - pop.
  - A full buffer with a pop in the same cycle cannot allocate that cycle; the request rule uses the registered count.
- Redirect, which has priority over everything else:
  - In the redirect cycle no request is issued and any pop is ignored.
  - All entries are invalidated: count = 0, pointers = 0.
  - fetch_pc = {redirect_pc[WORD_WIDTH-1:2], 2'b00}.
  - drop_cnt_next = drop_cnt + (allocated-unfilled entries) - (mem_rsp_valid ? 1 : 0). The same-cycle response is counted as stale and discarded.
  - Requests resume the next cycle, subject to count + drop_cnt < DEPTH.
- Back-to-back redirects accumulate drop_cnt correctly. drop_cnt never exceeds DEPTH; its width is log2(DEPTH)+1.
- if_ready low holds the head stable indefinitely; prefetch continues until count + drop_cnt = DEPTH.
- rst asserted mid-operation clears all state immediately. Responses arriving after reset with no outstanding request are outside this block's contract.

Test Plan:
- Zero-wait memory (ready = 1, response 1 cycle after acceptance), if_ready = 1 → fetches 0x0, 0x4, 0x8… on consecutive cycles; if_pc steps by 4, one instruction per cycle after a 2-cycle startup; if_pc4 = if_pc + 4.
- if_ready held low for 10 cycles → exactly 4 requests issued (addr 0x0–0xC), mem_req_valid then low; on release, instructions are delivered in order 0x0, 0x4, 0x8, 0xC with no gap before request 0x10 resumes.
- 3 requests outstanding (0x20, 0x24, 0x28) with redirect to 0x103 → next request addr 0x100; the 3 late responses are discarded; first if_pc = 0x100 with the instruction returned for it.
- Redirect coincident with mem_rsp_valid and with if_ready/if_valid → the pop is ignored and the response dropped; drop_cnt = previous unfilled - 1; no stale PC ever appears on if_pc.
- fetch_pc = 0xFFFFFFFC → next request addr 0x00000000; if_pc4 for that instruction = 0x00000000.
- rst pulsed asynchronously (mid-cycle) with 2 requests in flight → if_valid and mem_req_valid go low immediately; after release the first request is RESET_PC and the buffer is empty.

Source files
------------

// File: rtl/ifetch_buffer.sv
// Instruction prefetch queue: issues in-order word fetches ahead of the core,
// buffers returned instructions with their PCs and flushes on redirect.
module ifetch_buffer #(
  parameter int unsigned           DEPTH      = 4,
  parameter int unsigned           WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [WORD_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [WORD_WIDTH-1:0] mem_rsp_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [WORD_WIDTH-1:0] if_pc,
  output logic [WORD_WIDTH-1:0] if_pc4,
  output logic [WORD_WIDTH-1:0] if_instr,
  input  logic                  redirect,
  input  logic [WORD_WIDTH-1:0] redirect_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      unf_q, unf_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
  logic [PTR_W-1:0]      alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0]      fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0]      head_q, head_d;
  logic [DEPTH-1:0]      filled_q, filled_d;

  logic [WORD_WIDTH-1:0] pc_q    [DEPTH];
  logic [WORD_WIDTH-1:0] instr_q [DEPTH];

  logic alloc;
  logic rsp_drop;
  logic rsp_fill;
  logic pop;
  logic [1:0] unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Throttle on entries held plus stale responses still to come back
  assign mem_req_valid = !rst && !redirect &&
                         ((SUM_W'(count_q) + SUM_W'(drop_q)) < SUM_W'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;

  assign if_valid = filled_q[head_q];
  assign if_pc    = pc_q[head_q];
  assign if_pc4   = pc_q[head_q] + WORD_WIDTH'(4);
  assign if_instr = instr_q[head_q];

  assign alloc    = mem_req_valid && mem_req_ready;
  assign rsp_drop = mem_rsp_valid && (drop_q != '0);
  assign rsp_fill = mem_rsp_valid && (drop_q == '0) && !redirect;
  assign pop      = if_valid && if_ready && !redirect;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    unf_d       = unf_q;
    drop_d      = drop_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_d      = head_q;
    filled_d    = filled_q;

    if (redirect) begin
      // Every unfilled request, minus a response landing now, becomes stale
      fetch_pc_d  = {redirect_pc[WORD_WIDTH-1:2], 2'b00};
      count_d     = '0;
      unf_d       = '0;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_d      = '0;
      filled_d    = '0;
      drop_d      = drop_q + unf_q - CNT_W'(mem_rsp_valid);
    end else begin
      if (alloc) begin
        fetch_pc_d            = fetch_pc_q + WORD_WIDTH'(4);
        alloc_ptr_d           = alloc_ptr_q + PTR_W'(1);
        filled_d[alloc_ptr_q] = 1'b0;
      end
      if (rsp_drop) begin
        drop_d = drop_q - CNT_W'(1);
      end
      if (rsp_fill) begin
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        filled_d[head_q] = 1'b0;
        head_d           = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
      unf_d   = unf_q + CNT_W'(alloc) - CNT_W'(rsp_fill);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      count_q     <= '0;
      unf_q       <= '0;
      drop_q      <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_q      <= '0;
      filled_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      count_q     <= count_d;
      unf_q       <= unf_d;
      drop_q      <= drop_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_q      <= head_d;
      filled_q    <= filled_d;
    end
  end

  // Payload storage needs no reset; validity lives in filled_q
  always_ff @(posedge clk) begin
    if (alloc) begin
      pc_q[alloc_ptr_q] <= fetch_pc_q;
    end
    if (rsp_fill) begin
      instr_q[fill_ptr_q] <= mem_rsp_data;
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid |-> ((SUM_W'(unf_q) + SUM_W'(drop_q)) != '0));

endmodule

// File: tb/tb_ifetch_buffer.sv
// Directed bench for ifetch_buffer: table-driven streaming vectors plus
// hand-written redirect, wrap and asynchronous-reset sequences.
module tb_ifetch_buffer;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        rsp_hold;
  logic [31:0] mq[$];
  int          n_tests;
  int          n_fail;

  typedef struct {
    logic        rdy;
    logic        req_v;
    logic [31:0] addr;
    logic        ifv;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl_a [6];
  vec_t tbl_b [15];

  ifetch_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_pc         (if_pc),
    .if_pc4        (if_pc4),
    .if_instr      (if_instr),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic rdy, input logic req_v, input logic [31:0] addr,
                              input logic ifv, input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.req_v = req_v; v.addr = addr; v.ifv = ifv; v.pc = pc;
    return v;
  endfunction

  // In-order memory: answers one cycle after acceptance unless held
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end else begin
      if (mem_req_valid && mem_req_ready) mq.push_back(mem_req_addr);
      #1;
      if (!rsp_hold && mq.size() > 0) begin
        mem_rsp_data  = ins(mq.pop_front());
        mem_rsp_valid = 1'b1;
      end else begin
        mem_rsp_valid = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    if_ready      = 1'b1;
    mem_req_ready = 1'b1;
    rsp_hold      = 1'b0;
    #1;
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_if_valid", if_valid, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int idx);
    if_ready = v.rdy;
    #1;
    chk($sformatf("%s%0d_req_valid", tag, idx), mem_req_valid, v.req_v);
    if (v.req_v) chk($sformatf("%s%0d_req_addr", tag, idx), mem_req_addr, v.addr);
    chk($sformatf("%s%0d_if_valid", tag, idx), if_valid, v.ifv);
    if (v.ifv) begin
      chk($sformatf("%s%0d_if_pc", tag, idx), if_pc, v.pc);
      chk($sformatf("%s%0d_if_pc4", tag, idx), if_pc4, v.pc + 32'd4);
      chk($sformatf("%s%0d_if_instr", tag, idx), if_instr, ins(v.pc));
    end
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic found;
    n_tests       = 0;
    n_fail        = 0;
    rst           = 1'b1;
    mem_req_ready = 1'b1;
    if_ready      = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    rsp_hold      = 1'b0;

    // Zero-wait streaming with the core always ready
    tbl_a[0] = mk(1, 1, 32'h00, 0, 32'h00);
    tbl_a[1] = mk(1, 1, 32'h04, 0, 32'h00);
    tbl_a[2] = mk(1, 1, 32'h08, 1, 32'h00);
    tbl_a[3] = mk(1, 1, 32'h0C, 1, 32'h04);
    tbl_a[4] = mk(1, 1, 32'h10, 1, 32'h08);
    tbl_a[5] = mk(1, 1, 32'h14, 1, 32'h0C);
    // Core stalled ten cycles, then released
    tbl_b[0] = mk(0, 1, 32'h00, 0, 32'h00);
    tbl_b[1] = mk(0, 1, 32'h04, 0, 32'h00);
    tbl_b[2] = mk(0, 1, 32'h08, 1, 32'h00);
    tbl_b[3] = mk(0, 1, 32'h0C, 1, 32'h00);
    for (int i = 4; i < 10; i++) tbl_b[i] = mk(0, 0, 32'h00, 1, 32'h00);
    tbl_b[10] = mk(1, 0, 32'h00, 1, 32'h00);
    tbl_b[11] = mk(1, 1, 32'h10, 1, 32'h04);
    tbl_b[12] = mk(1, 1, 32'h14, 1, 32'h08);
    tbl_b[13] = mk(1, 1, 32'h18, 1, 32'h0C);
    tbl_b[14] = mk(1, 1, 32'h1C, 1, 32'h10);

    apply_reset();
    for (int i = 0; i < 6; i++) run_vec(tbl_a[i], "a", i);

    apply_reset();
    for (int i = 0; i < 15; i++) run_vec(tbl_b[i], "b", i);

    // Redirect together with a response and a pop
    apply_reset();
    for (int i = 0; i < 3; i++) run_vec(tbl_a[i], "d", i);
    if_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h202;
    #1;
    chk("d_redir_req_valid", mem_req_valid, 0);
    cycle();
    redirect = 1'b0;
    #1;
    chk("d_flush_if_valid", if_valid, 0);
    chk("d_req_addr0", mem_req_addr, 32'h200);
    cycle();
    #1;
    chk("d_if_valid1", if_valid, 0);
    chk("d_req_addr1", mem_req_addr, 32'h204);
    cycle();
    #1;
    chk("d_if_valid2", if_valid, 1);
    chk("d_if_pc", if_pc, 32'h200);
    chk("d_if_instr", if_instr, ins(32'h200));

    // Three requests outstanding, then redirect to an unaligned target
    apply_reset();
    if_ready    = 1'b0;
    rsp_hold    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h20;
    #1;
    chk("c_redir0_req_valid", mem_req_valid, 0);
    cycle();
    redirect = 1'b0;
    #1;
    chk("c_req_addr20", mem_req_addr, 32'h20);
    cycle();
    #1;
    chk("c_req_addr24", mem_req_addr, 32'h24);
    cycle();
    #1;
    chk("c_req_addr28", mem_req_addr, 32'h28);
    cycle();
    mem_req_ready = 1'b0;
    #1;
    chk("c_held_req_valid", mem_req_valid, 1);
    chk("c_held_req_addr", mem_req_addr, 32'h2C);
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    #1;
    chk("c_redir1_req_valid", mem_req_valid, 0);
    cycle();
    redirect      = 1'b0;
    rsp_hold      = 1'b0;
    mem_req_ready = 1'b1;
    if_ready      = 1'b1;
    #1;
    chk("c_req_valid100", mem_req_valid, 1);
    chk("c_req_addr100", mem_req_addr, 32'h100);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      #1;
      if (if_valid) found = 1'b1;
    end
    chk("c_first_seen", found, 1);
    chk("c_first_pc", if_pc, 32'h100);
    chk("c_first_instr", if_instr, ins(32'h100));
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      #1;
      if (if_valid) found = 1'b1;
    end
    chk("c_second_seen", found, 1);
    chk("c_second_pc", if_pc, 32'h104);

    // Fetch address wraps past the top of the address space
    apply_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect = 1'b0;
    #1;
    chk("e_req_addr_fff8", mem_req_addr, 32'hFFFF_FFF8);
    cycle();
    #1;
    chk("e_req_addr_fffc", mem_req_addr, 32'hFFFF_FFFC);
    cycle();
    #1;
    chk("e_req_addr_wrap", mem_req_addr, 32'h0);
    chk("e_if_pc_fff8", if_pc, 32'hFFFF_FFF8);
    cycle();
    #1;
    chk("e_if_pc_fffc", if_pc, 32'hFFFF_FFFC);
    chk("e_if_pc4_wrap", if_pc4, 32'h0);
    chk("e_if_instr_fffc", if_instr, ins(32'hFFFF_FFFC));
    cycle();
    #1;
    chk("e_if_pc_0", if_pc, 32'h0);
    chk("e_if_instr_0", if_instr, ins(32'h0));

    // Asynchronous reset mid-cycle with two fetches in flight
    apply_reset();
    if_ready = 1'b0;
    #1;
    chk("f_req_addr0", mem_req_addr, 32'h0);
    cycle();
    rsp_hold = 1'b1;
    cycle();
    cycle();
    #1;
    chk("f_pre_if_valid", if_valid, 1);
    chk("f_pre_if_pc", if_pc, 32'h0);
    chk("f_pre_req_addr", mem_req_addr, 32'h0C);
    #1;
    rst = 1'b1;
    #1;
    chk("f_async_if_valid", if_valid, 0);
    chk("f_async_req_valid", mem_req_valid, 0);
    cycle();
    rsp_hold = 1'b0;
    if_ready = 1'b1;
    rst      = 1'b0;
    #1;
    chk("f_post_req_valid", mem_req_valid, 1);
    chk("f_post_req_addr", mem_req_addr, 32'h0);
    chk("f_post_if_valid", if_valid, 0);
    cycle();
    #1;
    chk("f_post_if_valid1", if_valid, 0);
    chk("f_post_req_addr1", mem_req_addr, 32'h4);
    cycle();
    #1;
    chk("f_post_if_valid2", if_valid, 1);
    chk("f_post_if_pc", if_pc, 32'h0);
    chk("f_post_if_instr", if_instr, ins(32'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
